// File: rtl/booth_r4_seq_mult.sv
// Sequential radix-4 modified-Booth multiplier, signed or unsigned per operation.
// One Booth digit is retired per clock; the product is held until the next completion.
module booth_r4_seq_mult #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic               tc,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod,
  output logic               busy,
  output logic               done
);

  localparam int EW = WIDTH + 2;        // extended operand width
  localparam int PW = WIDTH + 3;        // partial-product / add window width
  localparam int LW = WIDTH + 2;        // retired low bits below the add window
  localparam int AW = PW + LW;          // full accumulator width
  localparam int D  = WIDTH / 2 + 1;    // Booth digits per operation
  localparam int CW = $clog2(D + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [EW-1:0]   m_reg;
  logic [EW:0]     q_reg;
  logic [AW-1:0]   acc;
  logic [CW-1:0]   cnt;

  logic            accept;
  logic            last_digit;
  logic [EW-1:0]   ext_a;
  logic [EW-1:0]   ext_b;
  logic [PW-1:0]   m_ext;
  logic [PW-1:0]   m_dbl;
  logic [PW-1:0]   pp;
  logic [PW-1:0]   upper_sum;
  logic [AW-1:0]   acc_add;
  logic [AW-1:0]   acc_step;

  // Handshake: load is taken on any rising edge where the block is not in RUN
  // (IDLE or DONE); busy is high exactly in RUN, done exactly in DONE, and prod
  // changes only on the edge that enters DONE.
  assign accept     = load && (state != RUN);
  assign last_digit = (cnt == CW'(D - 1));
  assign busy       = (state == RUN);
  assign done       = (state == DONE);

  always_comb begin
    ext_a = tc ? {{2{a[WIDTH-1]}}, a} : {2'b00, a};
    ext_b = tc ? {{2{b[WIDTH-1]}}, b} : {2'b00, b};
  end

  // Booth digit selection from the multiplier triplet {q[2],q[1],q[0]}
  always_comb begin
    m_ext = {m_reg[EW-1], m_reg};
    m_dbl = {m_reg, 1'b0};
    pp    = '0;
    case (q_reg[2:0])
      3'b001, 3'b010: pp = m_ext;
      3'b011:         pp = m_dbl;
      3'b100:         pp = ~m_dbl + PW'(1);
      3'b101, 3'b110: pp = ~m_ext + PW'(1);
      default:        pp = '0;
    endcase
  end

  always_comb begin
    upper_sum = acc[AW-1 -: PW] + pp;
    acc_add   = {upper_sum, acc[LW-1:0]};
    acc_step  = {{2{acc_add[AW-1]}}, acc_add[AW-1:2]};
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = RUN;
      RUN:     if (last_digit) state_next = DONE;
      DONE:    state_next = load ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // The add window sits above LW retired bits, so after D two-bit shifts the
  // full product lands in the low bits of the accumulator without truncation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_reg <= '0;
      q_reg <= '0;
      acc   <= '0;
      cnt   <= '0;
      prod  <= '0;
    end else if (accept) begin
      m_reg <= ext_a;
      q_reg <= {ext_b, 1'b0};
      acc   <= '0;
      cnt   <= '0;
    end else if (state == RUN) begin
      acc   <= acc_step;
      q_reg <= q_reg >> 2;
      cnt   <= cnt + CW'(1);
      if (last_digit) begin
        prod <= acc_step[2*WIDTH-1:0];
      end
    end
  end

endmodule
